// File: rtl/burst_clk_gen.sv
// Gated, stoppable clock burst: a start launches a square wave of period 2*HALF_PERIOD,
// each completed period adds STEP to acc, and the burst ends at LIMIT or on abort.
module burst_clk_gen #(
  parameter int CNT_W       = 8,
  parameter int STEP        = 10,
  parameter int LIMIT       = 50,
  parameter int HALF_PERIOD = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  output logic             clk_out,
  output logic             busy,
  output logic [CNT_W-1:0] acc,
  output logic             done,
  output logic             aborted,
  output logic             limit_flag
);

  // state | meaning
  // IDLE  | no burst; waits for start (ignored when abort is also high)
  // HIGH  | clk_out high phase, HALF_PERIOD cycles
  // LOW   | clk_out low phase; the last cycle completes a period and adds STEP

  localparam int PH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W:0]  STEP_X  = (CNT_W+1)'(STEP);
  localparam logic [CNT_W:0]  LIMIT_X = (CNT_W+1)'(LIMIT);

  if (LIMIT + STEP - 1 >= (1 << CNT_W)) begin : g_bad_limit
    $error("burst_clk_gen: LIMIT+STEP-1 must be below 2**CNT_W");
  end
  if (HALF_PERIOD < 1) begin : g_bad_half
    $error("burst_clk_gen: HALF_PERIOD must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t          state;
  logic [PH_W-1:0] ph;
  logic [CNT_W:0]  nxt;

  // One extra bit so the limit compare is immune to truncation.
  always_comb nxt = {1'b0, acc} + STEP_X;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      ph         <= '0;
      clk_out    <= 1'b0;
      busy       <= 1'b0;
      acc        <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      limit_flag <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state      <= HIGH;
            ph         <= '0;
            clk_out    <= 1'b1;
            busy       <= 1'b1;
            acc        <= '0;
            limit_flag <= 1'b0;
          end
        end
        HIGH, LOW: begin
          if (abort) begin
            state   <= IDLE;
            ph      <= '0;
            clk_out <= 1'b0;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (ph != PH_LAST) begin
            ph <= ph + 1'b1;
          end else if (state == HIGH) begin
            state   <= LOW;
            ph      <= '0;
            clk_out <= 1'b0;
          end else begin
            acc <= nxt[CNT_W-1:0];
            ph  <= '0;
            if (nxt >= LIMIT_X) begin
              state      <= IDLE;
              busy       <= 1'b0;
              done       <= 1'b1;
              limit_flag <= 1'b1;
            end else begin
              state   <= HIGH;
              clk_out <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          clk_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_clk_gen.sv
// Bench for burst_clk_gen: default instance plus a HALF_PERIOD=3/STEP=7/LIMIT=20 instance,
// both compared every cycle against an edge-count reference model.
module tb_burst_clk_gen;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic       clk_out0, busy0, done0, aborted0, limit_flag0;
  logic [7:0] acc0;
  logic       clk_out1, busy1, done1, aborted1, limit_flag1;
  logic [7:0] acc1;

  int vectors = 0;
  int errs = 0;

  // Reference state per instance: k = edges elapsed since the accepting edge.
  bit m_act[2];
  int m_k[2];
  int m_acc[2];
  bit m_done[2];
  bit m_abt[2];
  bit m_lim[2];

  always #5 clk = ~clk;

  burst_clk_gen u_dut0 (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .clk_out(clk_out0), .busy(busy0), .acc(acc0),
    .done(done0), .aborted(aborted0), .limit_flag(limit_flag0)
  );

  burst_clk_gen #(.CNT_W(8), .STEP(7), .LIMIT(20), .HALF_PERIOD(3)) u_dut1 (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .clk_out(clk_out1), .busy(busy1), .acc(acc1),
    .done(done1), .aborted(aborted1), .limit_flag(limit_flag1)
  );

  function automatic int hp(int d);
    return (d == 0) ? 1 : 3;
  endfunction
  function automatic int stp(int d);
    return (d == 0) ? 10 : 7;
  endfunction
  function automatic int lim(int d);
    return (d == 0) ? 50 : 20;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_k[d] = 0; m_acc[d] = 0;
      m_done[d] = 0; m_abt[d] = 0; m_lim[d] = 0;
    end
  endtask

  task automatic model_edge(input bit st, input bit ab);
    for (int d = 0; d < 2; d++) begin
      m_done[d] = 0;
      m_abt[d] = 0;
      if (!m_act[d]) begin
        if (st && !ab) begin
          m_act[d] = 1; m_k[d] = 0; m_acc[d] = 0; m_lim[d] = 0;
        end
      end else if (ab) begin
        m_act[d] = 0;
        m_abt[d] = 1;
      end else begin
        m_k[d]++;
        if (m_k[d] % (2 * hp(d)) == 0) begin
          m_acc[d] += stp(d);
          if (m_acc[d] >= lim(d)) begin
            m_act[d] = 0; m_done[d] = 1; m_lim[d] = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    bit exp_clk[2];
    for (int d = 0; d < 2; d++)
      exp_clk[d] = m_act[d] && ((m_k[d] % (2 * hp(d))) < hp(d));
    chk({tag, ".clk_out0"}, int'(clk_out0), int'(exp_clk[0]));
    chk({tag, ".busy0"}, int'(busy0), int'(m_act[0]));
    chk({tag, ".acc0"}, int'(acc0), m_acc[0] % 256);
    chk({tag, ".done0"}, int'(done0), int'(m_done[0]));
    chk({tag, ".aborted0"}, int'(aborted0), int'(m_abt[0]));
    chk({tag, ".limit0"}, int'(limit_flag0), int'(m_lim[0]));
    chk({tag, ".clk_out1"}, int'(clk_out1), int'(exp_clk[1]));
    chk({tag, ".busy1"}, int'(busy1), int'(m_act[1]));
    chk({tag, ".acc1"}, int'(acc1), m_acc[1] % 256);
    chk({tag, ".done1"}, int'(done1), int'(m_done[1]));
    chk({tag, ".aborted1"}, int'(aborted1), int'(m_abt[1]));
    chk({tag, ".limit1"}, int'(limit_flag1), int'(m_lim[1]));
  endtask

  task automatic step(input string tag, input bit st, input bit ab);
    start = st;
    abort = ab;
    @(posedge clk);
    model_edge(st, ab);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    check_all("rst");
    @(negedge clk);
    rstn = 1'b1;
    idle("post_rst", 2);

    // Full default burst: five periods, done after E10 with acc=50.
    step("burst_e0", 1'b1, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      step("burst", 1'b0, 1'b0);
      if (e == 4) chk("burst.acc_e4", int'(acc0), 20);
    end
    chk("burst.done_e10", int'(done0), 1);
    chk("burst.acc_e10", int'(acc0), 50);
    idle("burst_tail", 20);

    // Restart clears limit_flag on the accepting edge.
    step("restart_e0", 1'b1, 1'b0);
    chk("restart.limit_clr", int'(limit_flag0), 0);
    idle("restart", 24);

    // Abort sampled at E5 holds acc at 20.
    step("abort5_e0", 1'b1, 1'b0);
    idle("abort5", 4);
    step("abort5_e5", 1'b0, 1'b1);
    chk("abort5.acc", int'(acc0), 20);
    chk("abort5.pulse", int'(aborted0), 1);
    idle("abort5_tail", 4);

    // start+abort together in IDLE launches nothing.
    step("sa_idle", 1'b1, 1'b1);
    chk("sa_idle.busy", int'(busy0), 0);
    idle("sa_tail", 3);

    // Abort on the E4 completion edge wins over the increment.
    step("abort4_e0", 1'b1, 1'b0);
    idle("abort4", 3);
    step("abort4_e4", 1'b0, 1'b1);
    chk("abort4.acc", int'(acc0), 10);
    idle("abort4_tail", 4);

    // start re-asserted while busy has no effect.
    step("rebusy_e0", 1'b1, 1'b0);
    for (int e = 1; e <= 10; e++) step("rebusy", (e == 3 || e == 7), 1'b0);
    chk("rebusy.acc", int'(acc0), 50);
    idle("rebusy_tail", 12);

    // Wide-phase instance: acc 7,14,21 after E6,E12,E18.
    step("hp3_e0", 1'b1, 1'b0);
    for (int e = 1; e <= 18; e++) begin
      step("hp3", 1'b0, 1'b0);
      if (e == 6)  chk("hp3.acc_e6", int'(acc1), 7);
      if (e == 12) chk("hp3.acc_e12", int'(acc1), 14);
    end
    chk("hp3.acc_e18", int'(acc1), 21);
    chk("hp3.done_e18", int'(done1), 1);
    idle("hp3_tail", 3);

    // Async reset mid-burst at several phases.
    for (int r = 1; r <= 7; r += 2) begin
      step("rstmid_e0", 1'b1, 1'b0);
      idle("rstmid", r);
      async_reset("rstmid_chk");
      idle("rstmid_after", 3);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_rst");
      end else begin
        step("rnd", ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
